// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesters, the arbiter and the single spi_master.
// The master modport is the arbiter's view; slave is the view of the blocks around it.
`timescale 1ns/1ps
interface spi_req_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    m_start;
  logic [DATA_W-1:0]       m_data_wr;
  logic                    m_busy;
  logic                    m_done;
  logic [DATA_W-1:0]       m_data_rd;
  logic [N_REQ-1:0]        cs_n;

  modport master (
    input  req, req_data, m_busy, m_done, m_data_rd,
    output gnt, rsp_valid, rsp_data, rsp_err, m_start, m_data_wr, cs_n
  );

  modport slave (
    output req, req_data, m_busy, m_done, m_data_rd,
    input  gnt, rsp_valid, rsp_data, rsp_err, m_start, m_data_wr, cs_n
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one spi_master between N_REQ requesters, one byte per grant,
// with per-slave chip selects, a CS guard gap and a completion timeout.
`timescale 1ns/1ps
module spi_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_req_arbiter_if.master bus,
  output logic [1:0]        state_dbg
);
  // Handshakes: req is a level held until its gnt pulse; gnt, rsp_valid and
  // m_start are single-cycle pulses; m_done is a single-cycle pulse honoured in WAIT only.

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cur;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW-1:0] next_ptr;
  logic          found;
  logic [CW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;

  assign state_dbg = state;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    next_ptr = PW'((int'(win) + 1) % N_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur           <= '0;
      to_cnt        <= '0;
      gap_cnt       <= '0;
      bus.cs_n      <= '1;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.m_start   <= 1'b0;
      bus.m_data_wr <= '0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.m_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt       <= ONE << win;
            bus.cs_n      <= ~(ONE << win);
            bus.m_data_wr <= bus.req_data[int'(win)*DATA_W +: DATA_W];
            cur           <= win;
            rr_ptr        <= next_ptr;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (!bus.m_busy) begin
            bus.m_start <= 1'b1;
            to_cnt      <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // m_done takes priority over a timeout landing in the same cycle.
          if (bus.m_done) begin
            bus.rsp_valid <= ONE << cur;
            bus.rsp_data  <= bus.m_data_rd;
            bus.cs_n      <= '1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (to_cnt == TO_LAST) begin
            bus.rsp_valid <= ONE << cur;
            bus.rsp_err   <= 1'b1;
            bus.cs_n      <= '1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: stimulus pushes expected grants, master writes and
// responses into queues; monitor and spi_master model pop and compare as the DUT presents them.
`timescale 1ns/1ps
module tb_spi_req_arbiter;
  localparam int N_REQ      = 4;
  localparam int DATA_W     = 8;
  localparam int TIMEOUT    = 64;
  localparam int GAP_CYCLES = 2;
  localparam int RW = 1 + N_REQ + DATA_W;  // {err, rsp_valid, rsp_data}
  localparam int WW = N_REQ + DATA_W;      // {cs_n, m_data_wr} at m_start

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_req_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  spi_req_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [N_REQ-1:0]  exp_gnt_q[$];
  logic [RW-1:0]     exp_rsp_q[$];
  logic [WW-1:0]     exp_wr_q[$];
  logic [DATA_W-1:0] rd_table[N_REQ];
  int errors = 0;
  int checks = 0;
  int gnt_seen = 0;
  int rsp_seen = 0;
  int start_cyc = 0;
  int done_delay = 3;
  int inject_req = 0;
  int inject_ack = 0;
  int high_run = 1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within %0d cycles (cycle %0d)", name, budget, cyc);
  endtask

  task automatic push_txn(input logic [N_REQ-1:0] g, input logic [DATA_W-1:0] wr,
                          input logic [DATA_W-1:0] rd, input logic err);
    exp_gnt_q.push_back(g);
    exp_wr_q.push_back({~g, wr});
    exp_rsp_q.push_back({err, g, rd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) return;
    end
    timeout_fail("wait_gnt", budget);
  endtask

  task automatic wait_rsp(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) return;
    end
    timeout_fail("wait_rsp", budget);
  endtask

  task automatic wait_start(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.m_start) return;
    end
    timeout_fail("wait_start", budget);
  endtask

  task automatic wait_gnt_count(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (gnt_seen >= target) return;
    end
    timeout_fail("wait_gnt_count", budget);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && exp_wr_q.size() == 0) return;
    end
    timeout_fail("drain", budget);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gnt_seen++;
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 0);
        else check("gnt", 32'(bus.gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (bus.rsp_valid != '0) begin
        rsp_seen++;
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
        else check("rsp", 32'({bus.rsp_err, bus.rsp_valid, bus.rsp_data}),
                   32'(exp_rsp_q.pop_front()));
      end
      if (reset) begin
        high_run = 1000;
      end else if (bus.cs_n == '1) begin
        high_run++;
      end else begin
        check("cs_onehot", 32'($countones(~bus.cs_n)), 1);
        if (high_run > 0) check("cs_gap", 32'(high_run >= GAP_CYCLES), 1);
        high_run = 0;
      end
    end
  end

  // ---------------- spi_master model ----------------
  initial begin
    int w;
    bus.m_done    = 1'b0;
    bus.m_data_rd = '0;
    forever begin
      @(negedge clk);
      if (bus.m_start) begin
        w = 0;
        for (int i = 0; i < N_REQ; i++) if (!bus.cs_n[i]) w = i;
        start_cyc = cyc;
        if (exp_wr_q.size() == 0) check("m_start_unexpected", 32'(bus.m_start), 0);
        else check("m_start_cs_data", 32'({bus.cs_n, bus.m_data_wr}), 32'(exp_wr_q.pop_front()));
        if (done_delay >= 0) begin
          repeat (done_delay) @(negedge clk);
          bus.m_done    = 1'b1;
          bus.m_data_rd = rd_table[w];
          @(negedge clk);
          bus.m_done    = 1'b0;
          bus.m_data_rd = '0;
        end
      end else if (inject_req != inject_ack) begin
        inject_ack    = inject_req;
        bus.m_done    = 1'b1;
        bus.m_data_rd = 8'hEE;
        @(negedge clk);
        bus.m_done    = 1'b0;
        bus.m_data_rd = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int req_cyc;
    int f_cyc;
    int base;
    bus.req      = '0;
    bus.req_data = {8'h56, 8'h34, 8'h12, 8'hAB};
    bus.m_busy   = 1'b0;
    rd_table     = '{8'h5A, 8'hC1, 8'hC2, 8'hC3};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(bus.cs_n), 'hF);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_m_start", 32'(bus.m_start), 0);
    check("rst_m_data_wr", 32'(bus.m_data_wr), 0);
    check("rst_state", 32'(state_dbg), 0);
    reset = 1'b0;

    // 1: single transaction, master answers 3 cycles after m_start
    @(negedge clk);
    push_txn(4'b0001, 8'hAB, 8'h5A, 1'b0);
    req_cyc = cyc;
    bus.req = 4'b0001;
    wait_gnt(20);
    check("t1_latency", 32'(cyc - req_cyc), 1);
    check("t1_cs_n", 32'(bus.cs_n), 'hE);
    bus.req = '0;
    wait_rsp(40);
    check("t1_rsp_delay", 32'(cyc - start_cyc), 4);
    check("t1_cs_release", 32'(bus.cs_n), 'hF);
    drain(50);

    // 2: req 0101 held -> 0,2,0,2
    do_reset();
    push_txn(4'b0001, 8'hAB, 8'h5A, 1'b0);
    push_txn(4'b0100, 8'h34, 8'hC2, 1'b0);
    push_txn(4'b0001, 8'hAB, 8'h5A, 1'b0);
    push_txn(4'b0100, 8'h34, 8'hC2, 1'b0);
    base = gnt_seen;
    bus.req = 4'b0101;
    wait_gnt_count(base + 4, 200);
    bus.req = '0;
    drain(100);

    // 3: all requesting -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_txn(4'b0001, 8'hAB, 8'h5A, 1'b0);
      push_txn(4'b0010, 8'h12, 8'hC1, 1'b0);
      push_txn(4'b0100, 8'h34, 8'hC2, 1'b0);
      push_txn(4'b1000, 8'h56, 8'hC3, 1'b0);
    end
    base = gnt_seen;
    bus.req = 4'b1111;
    wait_gnt_count(base + 8, 300);
    bus.req = '0;
    drain(100);

    // 4: no m_done -> timeout 64 cycles after m_start; a request pulsed in GAP is dropped
    done_delay = -1;
    @(negedge clk);
    push_txn(4'b0010, 8'h12, 8'h00, 1'b1);
    bus.req = 4'b0010;
    wait_gnt(20);
    bus.req = '0;
    wait_rsp(100);
    check("t4_timeout_delay", 32'(cyc - start_cyc), 64);
    check("t4_cs_release", 32'(bus.cs_n), 'hF);
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = '0;
    repeat (6) @(negedge clk);
    done_delay = 3;

    // stray m_done while idle must be ignored
    inject_req++;
    repeat (8) @(negedge clk);
    check("stray_done_state", 32'(state_dbg), 0);

    // 5: m_busy holds SETUP; m_start the cycle after busy falls
    bus.m_busy = 1'b1;
    @(negedge clk);
    push_txn(4'b0001, 8'hAB, 8'h5A, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(20);
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      check("t5_cs_held", 32'(bus.cs_n), 'hE);
      check("t5_no_start", 32'(bus.m_start), 0);
      @(negedge clk);
    end
    check("t5_cs_held", 32'(bus.cs_n), 'hE);
    bus.m_busy = 1'b0;
    f_cyc = cyc;
    wait_rsp(40);
    check("t5_start_cycle", 32'(start_cyc), 32'(f_cyc + 1));
    drain(50);

    // 6: reset in WAIT releases everything at once, no response afterwards
    done_delay = -1;
    @(negedge clk);
    exp_gnt_q.push_back(4'b0100);
    exp_wr_q.push_back({4'b1011, 8'h34});
    bus.req = 4'b0100;
    wait_gnt(20);
    bus.req = '0;
    wait_start(20);
    repeat (5) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_cs_n", 32'(bus.cs_n), 'hF);
    check("t6_gnt", 32'(bus.gnt), 0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t6_m_start", 32'(bus.m_start), 0);
    check("t6_m_data_wr", 32'(bus.m_data_wr), 0);
    check("t6_state", 32'(state_dbg), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = rsp_seen;
    repeat (80) @(negedge clk);
    check("t6_no_rsp", 32'(rsp_seen - base), 0);
    done_delay = 3;

    check("queues_empty", 32'(exp_gnt_q.size() + exp_rsp_q.size() + exp_wr_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: bench did not complete by %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
